mmu_req_arbiter: RTL and testbench

- Shares the single MMU translation port between the instruction-fetch requester and the data (load/store/AMO) requester.
- Drives the MMU access-type code and holds it for the whole transaction.
- Tracks the MMU page-walk state to detect completion (TLB hit, page fault, or walk-then-retry) and returns a physical address or a fault cause to the winning requester.
- Sits between the CPU fetch/LSU front ends and the MMU; bypasses translation when the MMU reports translation off.

---
 rtl/mmu_req_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mmu_req_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_req_arbiter.sv
// Shares one MMU translation port between instruction fetch and the LSU, tracks the
// page walk to completion and returns a physical address or a fault cause to the winner.
module mmu_req_arbiter #(
  parameter logic [1:0] P_ACC_READ  = 2'd0,
  parameter logic [1:0] P_ACC_WRITE = 2'd1,
  parameter logic [1:0] P_ACC_CODE  = 2'd2,
  parameter logic [1:0] P_ACC_NONE  = 2'd3,
  parameter int         P_MAX_WALKS = 3,
  parameter int         P_TIMEOUT   = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_req,
  input  logic [31:0] i_vaddr,
  output logic        i_rsp,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_vaddr,
  output logic        d_rsp,
  output logic [31:0] rsp_paddr,
  output logic        rsp_fault,
  output logic [31:0] rsp_cause,
  output logic [1:0]  mmu_tlb_req,
  output logic [31:0] mmu_insn_addr,
  output logic [31:0] mmu_data_addr,
  input  logic        mmu_use_tlb,
  input  logic [2:0]  mmu_pw_state,
  input  logic [31:0] mmu_tlb_addr,
  input  logic [31:0] mmu_pagefault
);

  localparam int          WALK_W   = (P_MAX_WALKS > 1) ? $clog2(P_MAX_WALKS + 1) : 1;
  localparam int          TMO_W    = (P_TIMEOUT > 2) ? $clog2(P_TIMEOUT) : 1;
  localparam logic [WALK_W-1:0] WALK_LAST = WALK_W'(P_MAX_WALKS - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(P_TIMEOUT - 1);
  localparam logic [31:0] NO_FAULT     = 32'hFFFF_FFFF;
  localparam logic [31:0] CAUSE_FETCH  = 32'd12;
  localparam logic [31:0] CAUSE_LOAD   = 32'd13;
  localparam logic [31:0] CAUSE_STORE  = 32'd15;
  localparam logic [2:0]  PW_HIT       = 3'd7;
  localparam logic [2:0]  PW_WALKED    = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic              rr_data_q, rr_data_d;
  logic              is_data_q, is_data_d;
  logic              we_q, we_d;
  logic [31:0]       vaddr_q, vaddr_d;
  logic [WALK_W-1:0] walk_q, walk_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [31:0]       paddr_q, paddr_d;
  logic              fault_q, fault_d;
  logic [31:0]       cause_q, cause_d;

  logic              grant_data;
  logic              active;
  logic [1:0]        acc_code;
  logic [31:0]       forced_cause;
  logic [TMO_W-1:0]  tmo_inc;
  logic              unused_tlb_bits;

  assign unused_tlb_bits = ^{mmu_tlb_addr[31:22], mmu_tlb_addr[1:0]};

  // Data wins when it is alone or when the pointer favours it over a pending fetch.
  assign grant_data   = d_req && (!i_req || rr_data_q);
  assign acc_code     = !is_data_q ? P_ACC_CODE : (we_q ? P_ACC_WRITE : P_ACC_READ);
  assign forced_cause = !is_data_q ? CAUSE_FETCH : (we_q ? CAUSE_STORE : CAUSE_LOAD);
  assign tmo_inc      = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    rr_data_d = rr_data_q;
    is_data_d = is_data_q;
    we_d      = we_q;
    vaddr_d   = vaddr_q;
    walk_d    = walk_q;
    tmo_d     = tmo_q;
    paddr_d   = paddr_q;
    fault_d   = fault_q;
    cause_d   = cause_q;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          is_data_d = grant_data;
          we_d      = grant_data && d_we;
          vaddr_d   = grant_data ? d_vaddr : i_vaddr;
          rr_data_d = !grant_data;
          walk_d    = '0;
          tmo_d     = '0;
          state_d   = S_ISSUE;
        end
      end

      S_ISSUE: begin
        tmo_d = tmo_inc;
        if (!mmu_use_tlb) begin
          paddr_d = vaddr_q;
          fault_d = 1'b0;
          cause_d = NO_FAULT;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        tmo_d = tmo_inc;
        if (mmu_pw_state == PW_HIT) begin
          paddr_d = {mmu_tlb_addr[21:2], vaddr_q[11:0]};
          fault_d = 1'b0;
          cause_d = NO_FAULT;
          state_d = S_RESP;
        end else if (mmu_pw_state == PW_WALKED && mmu_pagefault != NO_FAULT) begin
          paddr_d = '0;
          fault_d = 1'b1;
          cause_d = mmu_pagefault;
          state_d = S_RESP;
        end else if ((mmu_pw_state == PW_WALKED && walk_q == WALK_LAST) || tmo_q == TMO_MAX) begin
          paddr_d = '0;
          fault_d = 1'b1;
          cause_d = forced_cause;
          state_d = S_RESP;
        end else if (mmu_pw_state == PW_WALKED) begin
          // Walk filled the TLB; stay put so the MMU re-looks-up and hits.
          walk_d = walk_q + 1'b1;
        end
      end

      S_RESP: begin
        walk_d  = '0;
        tmo_d   = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      rr_data_q <= 1'b1;
      is_data_q <= 1'b0;
      we_q      <= 1'b0;
      vaddr_q   <= '0;
      walk_q    <= '0;
      tmo_q     <= '0;
      paddr_q   <= '0;
      fault_q   <= 1'b0;
      cause_q   <= NO_FAULT;
    end else begin
      state_q   <= state_d;
      rr_data_q <= rr_data_d;
      is_data_q <= is_data_d;
      we_q      <= we_d;
      vaddr_q   <= vaddr_d;
      walk_q    <= walk_d;
      tmo_q     <= tmo_d;
      paddr_q   <= paddr_d;
      fault_q   <= fault_d;
      cause_q   <= cause_d;
    end
  end

  assign active        = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign mmu_tlb_req   = active ? acc_code : P_ACC_NONE;
  assign mmu_insn_addr = (active && !is_data_q) ? vaddr_q : 32'h0;
  assign mmu_data_addr = (active && is_data_q) ? vaddr_q : 32'h0;

  assign i_rsp     = (state_q == S_RESP) && !is_data_q;
  assign d_rsp     = (state_q == S_RESP) && is_data_q;
  assign rsp_paddr = paddr_q;
  assign rsp_fault = fault_q;
  assign rsp_cause = cause_q;

endmodule

// File: tb/tb_mmu_req_arbiter.sv
// Bench for mmu_req_arbiter: the bench plays the MMU; responses are checked against a queue
// of expectations pushed when each request is presented.
module tb_mmu_req_arbiter;

  logic        CLK;
  logic        RST;
  logic        i_req;
  logic [31:0] i_vaddr;
  logic        i_rsp;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_vaddr;
  logic        d_rsp;
  logic [31:0] rsp_paddr;
  logic        rsp_fault;
  logic [31:0] rsp_cause;
  logic [1:0]  mmu_tlb_req;
  logic [31:0] mmu_insn_addr;
  logic [31:0] mmu_data_addr;
  logic        mmu_use_tlb;
  logic [2:0]  mmu_pw_state;
  logic [31:0] mmu_tlb_addr;
  logic [31:0] mmu_pagefault;

  typedef struct {
    logic        is_data;
    logic [31:0] paddr;
    logic        fault;
    logic [31:0] cause;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors;
  int   miscompares;

  mmu_req_arbiter dut (
    .CLK           (CLK),
    .RST           (RST),
    .i_req         (i_req),
    .i_vaddr       (i_vaddr),
    .i_rsp         (i_rsp),
    .d_req         (d_req),
    .d_we          (d_we),
    .d_vaddr       (d_vaddr),
    .d_rsp         (d_rsp),
    .rsp_paddr     (rsp_paddr),
    .rsp_fault     (rsp_fault),
    .rsp_cause     (rsp_cause),
    .mmu_tlb_req   (mmu_tlb_req),
    .mmu_insn_addr (mmu_insn_addr),
    .mmu_data_addr (mmu_data_addr),
    .mmu_use_tlb   (mmu_use_tlb),
    .mmu_pw_state  (mmu_pw_state),
    .mmu_tlb_addr  (mmu_tlb_addr),
    .mmu_pagefault (mmu_pagefault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Response monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (i_rsp || d_rsp) begin
      vectors++;
      if (i_rsp && d_rsp) begin
        miscompares++;
        $display("FAIL double_pulse: i_rsp=%0b d_rsp=%0b required one only", i_rsp, d_rsp);
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rsp: i_rsp=%0b d_rsp=%0b with nothing outstanding", i_rsp, d_rsp);
      end else begin
        mon_e = exp_q.pop_front();
        if (d_rsp !== mon_e.is_data || rsp_fault !== mon_e.fault || rsp_cause !== mon_e.cause ||
            (!mon_e.fault && rsp_paddr !== mon_e.paddr)) begin
          miscompares++;
          $display("FAIL rsp_content: got data=%0b paddr=%h fault=%0b cause=%h required data=%0b paddr=%h fault=%0b cause=%h",
                   d_rsp, rsp_paddr, rsp_fault, rsp_cause,
                   mon_e.is_data, mon_e.paddr, mon_e.fault, mon_e.cause);
        end
      end
    end
  end

  task automatic push_exp(input logic is_data, input logic [31:0] paddr,
                          input logic fault, input logic [31:0] cause);
    exp_t e;
    e.is_data = is_data;
    e.paddr   = paddr;
    e.fault   = fault;
    e.cause   = cause;
    exp_q.push_back(e);
  endtask

  task automatic wait_rsp(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (!(i_rsp || d_rsp) && cyc < limit);
  endtask

  task automatic test_reset;
    RST = 1'b1;
    i_req = 0; i_vaddr = 0; d_req = 0; d_we = 0; d_vaddr = 0;
    mmu_use_tlb = 0; mmu_pw_state = 0; mmu_tlb_addr = 0; mmu_pagefault = 32'hFFFF_FFFF;
    repeat (3) @(negedge CLK);
    vectors++;
    if (mmu_tlb_req !== 2'd3 || i_rsp !== 1'b0 || d_rsp !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: tlb_req=%0d i_rsp=%0b d_rsp=%0b required 3/0/0", mmu_tlb_req, i_rsp, d_rsp);
    end
    vectors++;
    if (rsp_paddr !== 32'h0 || rsp_fault !== 1'b0 || rsp_cause !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL reset_rsp: paddr=%h fault=%0b cause=%h required 0/0/ffffffff", rsp_paddr, rsp_fault, rsp_cause);
    end
    vectors++;
    if (mmu_insn_addr !== 32'h0 || mmu_data_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_addr: insn=%h data=%h required 0/0", mmu_insn_addr, mmu_data_addr);
    end
    RST = 1'b0;
  endtask

  task automatic test_bypass;
    int cyc;
    mmu_use_tlb = 0;
    i_req = 1; i_vaddr = 32'h8000_1234;
    push_exp(1'b0, 32'h8000_1234, 1'b0, 32'hFFFF_FFFF);
    @(negedge CLK);
    vectors++;
    if (mmu_tlb_req !== 2'd2 || mmu_insn_addr !== 32'h8000_1234 || mmu_data_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL bypass_issue: tlb_req=%0d insn=%h data=%h required 2/80001234/0", mmu_tlb_req, mmu_insn_addr, mmu_data_addr);
    end
    wait_rsp(20, cyc);
    vectors++;
    if (cyc !== 1 || i_rsp !== 1'b1) begin
      miscompares++;
      $display("FAIL bypass_latency: rsp after %0d more cycles (i_rsp=%0b) required 1", cyc, i_rsp);
    end
    i_req = 0;
    @(negedge CLK);
    vectors++;
    if (i_rsp !== 1'b0 || mmu_tlb_req !== 2'd3 || rsp_paddr !== 32'h8000_1234) begin
      miscompares++;
      $display("FAIL bypass_hold: i_rsp=%0b tlb_req=%0d paddr=%h required 0/3/80001234", i_rsp, mmu_tlb_req, rsp_paddr);
    end
  endtask

  task automatic test_tlb_hit;
    int cyc;
    mmu_use_tlb = 1; mmu_pw_state = 0;
    d_req = 1; d_we = 0; d_vaddr = 32'hC001_2ABC;
    push_exp(1'b1, 32'h00FC_1ABC, 1'b0, 32'hFFFF_FFFF);
    @(negedge CLK);
    vectors++;
    if (mmu_tlb_req !== 2'd0 || mmu_data_addr !== 32'hC001_2ABC || mmu_insn_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL hit_issue: tlb_req=%0d data=%h insn=%h required 0/c0012abc/0", mmu_tlb_req, mmu_data_addr, mmu_insn_addr);
    end
    @(negedge CLK);
    vectors++;
    if (mmu_tlb_req !== 2'd0 || d_rsp !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_wait: tlb_req=%0d d_rsp=%0b required 0/0", mmu_tlb_req, d_rsp);
    end
    mmu_pw_state = 3'd7; mmu_tlb_addr = 32'h0000_3F04;
    wait_rsp(20, cyc);
    vectors++;
    if (cyc !== 1 || d_rsp !== 1'b1 || mmu_tlb_req !== 2'd3) begin
      miscompares++;
      $display("FAIL hit_latency: cycles=%0d d_rsp=%0b tlb_req=%0d required 1/1/3", cyc, d_rsp, mmu_tlb_req);
    end
    mmu_pw_state = 0; d_req = 0;
    @(negedge CLK);
  endtask

  task automatic test_miss_then_hit;
    int cyc;
    mmu_use_tlb = 1; mmu_pw_state = 0; mmu_pagefault = 32'hFFFF_FFFF;
    d_req = 1; d_we = 0; d_vaddr = 32'h1234_5678;
    push_exp(1'b1, 32'h0040_0678, 1'b0, 32'hFFFF_FFFF);
    repeat (2) @(negedge CLK);
    mmu_pw_state = 3'd5;
    @(negedge CLK);
    vectors++;
    if (d_rsp !== 1'b0 || mmu_tlb_req !== 2'd0) begin
      miscompares++;
      $display("FAIL walk_stays: d_rsp=%0b tlb_req=%0d required 0/0", d_rsp, mmu_tlb_req);
    end
    mmu_pw_state = 3'd0;
    @(negedge CLK);
    mmu_pw_state = 3'd7; mmu_tlb_addr = 32'h0000_1000;
    wait_rsp(20, cyc);
    vectors++;
    if (cyc !== 1 || d_rsp !== 1'b1) begin
      miscompares++;
      $display("FAIL miss_hit_rsp: cycles=%0d d_rsp=%0b required 1/1", cyc, d_rsp);
    end
    mmu_pw_state = 0; d_req = 0;
    @(negedge CLK);
  endtask

  task automatic test_store_fault;
    int cyc;
    mmu_use_tlb = 1; mmu_pw_state = 0;
    d_req = 1; d_we = 1; d_vaddr = 32'h4000_0010;
    push_exp(1'b1, 32'h0, 1'b1, 32'd15);
    repeat (2) @(negedge CLK);
    vectors++;
    if (mmu_tlb_req !== 2'd1) begin
      miscompares++;
      $display("FAIL store_code: tlb_req=%0d required 1", mmu_tlb_req);
    end
    mmu_pw_state = 3'd5; mmu_pagefault = 32'd15;
    wait_rsp(20, cyc);
    vectors++;
    if (cyc !== 1 || d_rsp !== 1'b1) begin
      miscompares++;
      $display("FAIL store_fault_rsp: cycles=%0d d_rsp=%0b required 1/1", cyc, d_rsp);
    end
    d_req = 0; d_we = 0; mmu_pw_state = 0; mmu_pagefault = 32'hFFFF_FFFF;
    mmu_use_tlb = 0; i_req = 1; i_vaddr = 32'h0000_0ABC;
    push_exp(1'b0, 32'h0000_0ABC, 1'b0, 32'hFFFF_FFFF);
    @(negedge CLK);
    vectors++;
    if (mmu_tlb_req !== 2'd3) begin
      miscompares++;
      $display("FAIL idle_gap: tlb_req=%0d required 3", mmu_tlb_req);
    end
    @(negedge CLK);
    vectors++;
    if (mmu_tlb_req !== 2'd2) begin
      miscompares++;
      $display("FAIL next_accept: tlb_req=%0d required 2", mmu_tlb_req);
    end
    wait_rsp(20, cyc);
    i_req = 0;
    @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    int n;
    int cyc;
    mmu_use_tlb = 0;
    i_req = 1; i_vaddr = 32'h0001_1000;
    d_req = 1; d_we = 0; d_vaddr = 32'h0002_2000;
    for (int k = 0; k < 2; k++) begin
      push_exp(1'b1, 32'h0002_2000, 1'b0, 32'hFFFF_FFFF);
      push_exp(1'b0, 32'h0001_1000, 1'b0, 32'hFFFF_FFFF);
    end
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 60) begin
      @(negedge CLK);
      cyc++;
      if (i_rsp || d_rsp) n++;
    end
    i_req = 0; d_req = 0;
    vectors++;
    if (n !== 4) begin
      miscompares++;
      $display("FAIL b2b_count: responses=%0d required 4", n);
    end
    @(negedge CLK);
  endtask

  task automatic test_timeout;
    int cyc;
    int act;
    mmu_use_tlb = 1; mmu_pw_state = 0;
    i_req = 1; i_vaddr = 32'h0000_2000;
    push_exp(1'b0, 32'h0, 1'b1, 32'd12);
    cyc = 0;
    act = 0;
    do begin
      @(negedge CLK);
      cyc++;
      if (mmu_tlb_req !== 2'd3) act++;
    end while (!i_rsp && cyc < 3000);
    i_req = 0;
    vectors++;
    if (i_rsp !== 1'b1 || act !== 1024) begin
      miscompares++;
      $display("FAIL timeout: i_rsp=%0b active_cycles=%0d required 1/1024", i_rsp, act);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    mmu_use_tlb = 1; mmu_pw_state = 0;
    d_req = 1; d_we = 0; d_vaddr = 32'h0000_5000;
    repeat (4) @(negedge CLK);
    vectors++;
    if (mmu_tlb_req !== 2'd0) begin
      miscompares++;
      $display("FAIL mid_wait: tlb_req=%0d required 0", mmu_tlb_req);
    end
    RST = 1; d_req = 0;
    @(negedge CLK);
    vectors++;
    if (mmu_tlb_req !== 2'd3 || d_rsp !== 1'b0 || rsp_fault !== 1'b0 ||
        rsp_cause !== 32'hFFFF_FFFF || rsp_paddr !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset: tlb_req=%0d d_rsp=%0b fault=%0b cause=%h paddr=%h required 3/0/0/ffffffff/0",
               mmu_tlb_req, d_rsp, rsp_fault, rsp_cause, rsp_paddr);
    end
    RST = 0;
    repeat (6) @(negedge CLK);
    vectors++;
    if (rsp_fault !== 1'b0 || mmu_tlb_req !== 2'd3) begin
      miscompares++;
      $display("FAIL post_reset_quiet: fault=%0b tlb_req=%0d required 0/3", rsp_fault, mmu_tlb_req);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_bypass();
    test_tlb_hit();
    test_miss_then_hit();
    test_store_fault();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL outstanding: %0d expected responses never arrived, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
